// File: rtl/ip_pkg.sv
// Shared IPv4 definitions: decoder state encoding, header constants,
// error bit positions and the ones-complement adder used by both the
// encoder and the decoder.
package ip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_OPT,
    ST_PAYLOAD,
    ST_DROP
  } ip_state_e;

  localparam logic [5:0] IP_HDR_MIN_BYTES = 6'd20;
  localparam logic [3:0] IP_VERSION       = 4'd4;
  localparam logic [7:0] IP_PROTO_TCP     = 8'h06;

  localparam int unsigned ERR_VER   = 0;
  localparam int unsigned ERR_LEN   = 1;
  localparam int unsigned ERR_CSUM  = 2;
  localparam int unsigned ERR_PROTO = 3;

  // 16-bit ones-complement add with end-around carry.
  function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/csum16_acc.sv
// Header checksum accumulator. Even bytes are held as the high half of a
// big-endian word; each odd byte completes the word, which is added with
// end-around carry. sum_o already includes the word completed this cycle,
// so the caller can judge the header on its final byte.
module csum16_acc
  import ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        odd_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [7:0]  hi_q;
  logic [15:0] acc_q;
  logic [15:0] acc_d;

  // Next accumulator value: clear restarts from zero, an odd byte adds a word.
  always_comb begin
    acc_d = clr_i ? 16'h0000 : acc_q;
    if (en_i && odd_i) begin
      acc_d = ones_add16(acc_d, {hi_q, byte_i});
    end
  end

  assign sum_o = acc_d;

  // Hold the running sum and the pending high byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= 8'h00;
      acc_q <= 16'h0000;
    end else begin
      if (en_i || clr_i) acc_q <= acc_d;
      if (en_i && !odd_i) hi_q <= byte_i;
    end
  end

endmodule

// File: rtl/ip_decode.sv
// IPv4 receive header decoder: parses and validates the header, skips
// options, and forwards total_length - 4*IHL payload bytes when the header
// is clean. Defining IP_DECODE_CSUM_EN builds the header checksum check;
// without it err[2] is tied low and the checksum field is ignored.
module ip_decode
  import ip_pkg::*;
#(
  parameter logic [7:0] PROTO = IP_PROTO_TCP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        hdr_done,
  output logic        hdr_ok,
  output logic [3:0]  err,
  output logic [31:0] src_addr,
  output logic [31:0] dst_addr,
  output logic [15:0] total_len,
  output logic [7:0]  ttl,
  output logic [7:0]  proto,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pl_last
);

  ip_state_e   state_q;
  logic [5:0]  cnt_q;
  logic [3:0]  ver_q;
  logic [3:0]  ihl_q;
  logic [23:0] sh_q;
  logic [15:0] pay_q;

  logic        hdr_done_q, hdr_ok_q, pl_valid_q, pl_last_q;
  logic [3:0]  err_q;
  logic [31:0] src_q, dst_q;
  logic [15:0] total_len_q;
  logic [7:0]  ttl_q, proto_q, pl_data_q;

  logic [5:0]  hdr_len;
  logic        hdr_last;
  logic [3:0]  err_now;
  logic [15:0] pay_len;
  logic        csum_bad;

`ifdef IP_DECODE_CSUM_EN
  logic        in_hdr;
  logic [15:0] csum_sum;

  assign in_hdr = (state_q == ST_HDR) || (state_q == ST_OPT);

  csum16_acc u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (din_valid && sof),
    .en_i   (din_valid && (sof || in_hdr)),
    .odd_i  (sof ? 1'b0 : cnt_q[0]),
    .byte_i (din),
    .sum_o  (csum_sum)
  );

  assign csum_bad = (csum_sum != 16'hFFFF);
`else
  assign csum_bad = 1'b0;
`endif

  // Header length, error summary and payload length for the final header byte.
  always_comb begin
    hdr_len            = (ihl_q < 4'd5) ? IP_HDR_MIN_BYTES : {ihl_q, 2'b00};
    hdr_last           = (cnt_q == hdr_len - 6'd1);
    err_now            = 4'h0;
    err_now[ERR_VER]   = (ver_q != IP_VERSION);
    err_now[ERR_LEN]   = (ihl_q < 4'd5) || (total_len_q < {10'd0, ihl_q, 2'b00});
    err_now[ERR_CSUM]  = csum_bad;
    err_now[ERR_PROTO] = (proto_q != PROTO);
    pay_len            = (total_len_q >= {10'd0, hdr_len}) ? total_len_q - {10'd0, hdr_len} : 16'd0;
  end

  // Packet FSM with registered outputs; idle input cycles freeze everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      ver_q       <= 4'd0;
      ihl_q       <= 4'd0;
      sh_q        <= 24'd0;
      pay_q       <= 16'd0;
      hdr_done_q  <= 1'b0;
      hdr_ok_q    <= 1'b0;
      err_q       <= 4'h0;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
      total_len_q <= 16'd0;
      ttl_q       <= 8'd0;
      proto_q     <= 8'd0;
      pl_data_q   <= 8'd0;
      pl_valid_q  <= 1'b0;
      pl_last_q   <= 1'b0;
    end else begin
      hdr_done_q <= 1'b0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      if (din_valid) begin
        if (sof) begin
          // A start byte always restarts parsing, abandoning any packet in flight.
          state_q  <= ST_HDR;
          cnt_q    <= 6'd1;
          ver_q    <= din[7:4];
          ihl_q    <= din[3:0];
          sh_q     <= {16'd0, din};
          err_q    <= 4'h0;
          hdr_ok_q <= 1'b0;
        end else begin
          case (state_q)
            ST_HDR, ST_OPT: begin
              cnt_q <= cnt_q + 6'd1;
              sh_q  <= {sh_q[15:0], din};
              case (cnt_q)
                6'd3:    total_len_q <= {sh_q[7:0], din};
                6'd8:    ttl_q       <= din;
                6'd9:    proto_q     <= din;
                6'd15:   src_q       <= {sh_q, din};
                6'd19:   dst_q       <= {sh_q, din};
                default: ;
              endcase
              if (hdr_last) begin
                hdr_done_q <= 1'b1;
                err_q      <= err_now;
                hdr_ok_q   <= (err_now == 4'h0);
                pay_q      <= pay_len;
                if (pay_len == 16'd0)      state_q <= ST_IDLE;
                else if (err_now == 4'h0)  state_q <= ST_PAYLOAD;
                else                       state_q <= ST_DROP;
              end else if (cnt_q == IP_HDR_MIN_BYTES - 6'd1) begin
                state_q <= ST_OPT;
              end
            end
            ST_PAYLOAD: begin
              pl_valid_q <= 1'b1;
              pl_data_q  <= din;
              pay_q      <= pay_q - 16'd1;
              if (pay_q == 16'd1) begin
                pl_last_q <= 1'b1;
                state_q   <= ST_IDLE;
              end
            end
            ST_DROP: begin
              pay_q <= pay_q - 16'd1;
              if (pay_q == 16'd1) state_q <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign hdr_done  = hdr_done_q;
  assign hdr_ok    = hdr_ok_q;
  assign err       = err_q;
  assign src_addr  = src_q;
  assign dst_addr  = dst_q;
  assign total_len = total_len_q;
  assign ttl       = ttl_q;
  assign proto     = proto_q;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pl_last   = pl_last_q;

endmodule

// File: tb/tb_ip_decode.sv
// Randomized bench for ip_decode with a packet-level reference model.
`timescale 1ns/1ps
module tb_ip_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        hdr_done, hdr_ok, pl_valid, pl_last;
  logic [3:0]  err;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] total_len;
  logic [7:0]  ttl, proto, pl_data;

  ip_decode #(.PROTO(8'h06)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .din(din), .din_valid(din_valid),
    .hdr_done(hdr_done), .hdr_ok(hdr_ok), .err(err),
    .src_addr(src_addr), .dst_addr(dst_addr), .total_len(total_len),
    .ttl(ttl), .proto(proto),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic [3:0]  e;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] tlen;
    logic [7:0]  ttl;
    logic [7:0]  proto;
  } hdr_rec_t;

  hdr_rec_t   exp_h[$];
  hdr_rec_t   got_h[$];
  logic [8:0] exp_p[$];
  logic [8:0] got_p[$];
  logic [7:0] pkt[$];
  logic [7:0] nom_hdr [0:19];
  hdr_rec_t   mon_r;
  logic [3:0] exp_err_last = 4'h0;
  logic       exp_ok_last = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         got_hdr_cyc = 0;
  int         exp_hdr_cyc = 0;

  always @(posedge clk) cyc++;

  // Monitor: record header results and payload beats away from the clock edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_done) begin
        mon_r.ok = hdr_ok; mon_r.e = err; mon_r.src = src_addr; mon_r.dst = dst_addr;
        mon_r.tlen = total_len; mon_r.ttl = ttl; mon_r.proto = proto;
        got_h.push_back(mon_r);
        got_hdr_cyc = cyc;
      end
      if (pl_valid) got_p.push_back({pl_last, pl_data});
      else if (pl_last) got_p.push_back(9'h1FF);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fold_sum(input int hl);
    int unsigned s;
    s = 0;
    for (int i = 0; i < hl / 2; i++) s += {16'd0, pkt[2*i], pkt[2*i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic int hlen_of(input logic [3:0] ihl);
    return (ihl < 4'd5) ? 20 : 4 * int'(ihl);
  endfunction

  task automatic build_pkt(input logic [3:0] ver, input logic [3:0] ihl, input int paylen,
                           input bit short_len, input logic [7:0] proto_v, input bit bad_csum);
    int hl;
    logic [15:0] tl, c;
    hl = hlen_of(ihl);
    tl = short_len ? 16'(hl - 4) : 16'(hl + paylen);
    pkt = {};
    pkt.push_back({ver, ihl}); pkt.push_back(8'h00);
    pkt.push_back(tl[15:8]);   pkt.push_back(tl[7:0]);
    pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom));
    pkt.push_back(8'h40); pkt.push_back(8'h00);
    pkt.push_back(8'($urandom_range(255, 1))); pkt.push_back(proto_v);
    pkt.push_back(8'h00); pkt.push_back(8'h00);
    for (int i = 12; i < hl; i++) pkt.push_back(8'($urandom));
    c = ~fold_sum(hl);
    if (bad_csum) c = c ^ 16'h0001;
    pkt[10] = c[15:8];
    pkt[11] = c[7:0];
    if (!short_len) for (int i = 0; i < paylen; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic load_nominal();
    pkt = {};
    for (int i = 0; i < 20; i++) pkt.push_back(nom_hdr[i]);
    for (int i = 0; i < 20; i++) pkt.push_back(8'($urandom));
  endtask

  // Reference: expected header record and payload beats when n bytes of pkt are sent.
  task automatic model_pkt(input int n);
    logic [3:0]  e;
    logic [15:0] tl;
    int hl, plen;
    hdr_rec_t r;
    exp_err_last = 4'h0;
    exp_ok_last  = 1'b0;
    hl = hlen_of(pkt[0][3:0]);
    if (n < hl) return;
    tl = {pkt[2], pkt[3]};
    e = 4'h0;
    e[0] = (pkt[0][7:4] != 4'd4);
    e[1] = (pkt[0][3:0] < 4'd5) || (int'(tl) < 4 * int'(pkt[0][3:0]));
`ifdef IP_DECODE_CSUM_EN
    e[2] = (fold_sum(hl) != 16'hFFFF);
`endif
    e[3] = (pkt[9] != 8'h06);
    r.ok = (e == 4'h0); r.e = e;
    r.src = {pkt[12], pkt[13], pkt[14], pkt[15]};
    r.dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
    r.tlen = tl; r.ttl = pkt[8]; r.proto = pkt[9];
    exp_h.push_back(r);
    exp_err_last = e;
    exp_ok_last  = r.ok;
    plen = (int'(tl) >= hl) ? int'(tl) - hl : 0;
    if (e == 4'h0)
      for (int k = 0; k < plen && hl + k < n; k++) exp_p.push_back({k == plen - 1, pkt[hl + k]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b0; sof = 1'($urandom_range(1, 0)); din = 8'($urandom);
    end
  endtask

  task automatic send_pkt(input int n, input int gap_max);
    int hl;
    hl = hlen_of(pkt[0][3:0]);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
      @(negedge clk);
      din_valid = 1'b1; sof = (i == 0); din = pkt[i];
      if (i == hl - 1) exp_hdr_cyc = cyc + 1;
    end
  endtask

  task automatic send_junk(input int n);
    repeat (n) begin
      @(negedge clk);
      din_valid = 1'b1; sof = 1'b0; din = 8'($urandom);
    end
  endtask

  task automatic compare_all(input string tag);
    idle(4);
    @(negedge clk);
    din_valid = 1'b0; sof = 1'b0;
    chk({tag, "_nhdr"}, 64'(got_h.size()), 64'(exp_h.size()));
    for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
      chk({tag, "_ok"},    64'(got_h[i].ok),    64'(exp_h[i].ok));
      chk({tag, "_err"},   64'(got_h[i].e),     64'(exp_h[i].e));
      chk({tag, "_src"},   64'(got_h[i].src),   64'(exp_h[i].src));
      chk({tag, "_dst"},   64'(got_h[i].dst),   64'(exp_h[i].dst));
      chk({tag, "_tlen"},  64'(got_h[i].tlen),  64'(exp_h[i].tlen));
      chk({tag, "_ttl"},   64'(got_h[i].ttl),   64'(exp_h[i].ttl));
      chk({tag, "_proto"}, 64'(got_h[i].proto), 64'(exp_h[i].proto));
    end
    chk({tag, "_nbeats"}, 64'(got_p.size()), 64'(exp_p.size()));
    for (int i = 0; i < exp_p.size() && i < got_p.size(); i++)
      chk({tag, "_beat"}, 64'(got_p[i]), 64'(exp_p[i]));
    chk({tag, "_err_hold"}, 64'(err), 64'(exp_err_last));
    chk({tag, "_ok_hold"},  64'(hdr_ok), 64'(exp_ok_last));
    exp_h = {}; got_h = {}; exp_p = {}; got_p = {};
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hdr_done"}, 64'(hdr_done), 0);
    chk({tag, "_hdr_ok"},   64'(hdr_ok), 0);
    chk({tag, "_err"},      64'(err), 0);
    chk({tag, "_src"},      64'(src_addr), 0);
    chk({tag, "_dst"},      64'(dst_addr), 0);
    chk({tag, "_tlen"},     64'(total_len), 0);
    chk({tag, "_ttl"},      64'(ttl), 0);
    chk({tag, "_proto"},    64'(proto), 0);
    chk({tag, "_pl_data"},  64'(pl_data), 0);
    chk({tag, "_pl_valid"}, 64'(pl_valid), 0);
    chk({tag, "_pl_last"},  64'(pl_last), 0);
  endtask

  initial begin
    int n_full, n_send;
    logic [3:0] v, ih;
    nom_hdr = '{8'h45, 8'h00, 8'h00, 8'h28, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h06,
                8'hB7, 8'h7B, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h02};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Nominal packet.
    load_nominal();
    model_pkt(40);
    send_pkt(40, 0);
    chk("nom_hdr_cycle", 64'(got_hdr_cyc), 64'(exp_hdr_cyc));
    compare_all("nom");
    chk("nom_src",  64'(src_addr), 64'h0000_0000_C0A8_0101);
    chk("nom_dst",  64'(dst_addr), 64'h0000_0000_C0A8_0102);
    chk("nom_tlen", 64'(total_len), 64'h28);
    chk("nom_ok",   64'(hdr_ok), 1);
    chk("nom_err",  64'(err), 0);

    // Bad checksum, followed by a packet that must parse from IDLE.
    load_nominal();
    pkt[11] = 8'h7C;
    model_pkt(40);
    send_pkt(40, 1);
    compare_all("badcs");
`ifdef IP_DECODE_CSUM_EN
    chk("badcs_ok",  64'(hdr_ok), 0);
    chk("badcs_err2", 64'(err[2]), 1);
`else
    chk("badcs_ok",  64'(hdr_ok), 1);
    chk("badcs_err2", 64'(err[2]), 0);
`endif

    // Options: IHL=6, total length 0x2C.
    build_pkt(4'd4, 4'd6, 20, 1'b0, 8'h06, 1'b0);
    model_pkt(44);
    send_pkt(44, 0);
    chk("opt_hdr_cycle", 64'(got_hdr_cyc), 64'(exp_hdr_cyc));
    compare_all("opt");
    chk("opt_tlen", 64'(total_len), 64'h2C);

    // Protocol mismatch with a correct checksum.
    build_pkt(4'd4, 4'd5, 16, 1'b0, 8'h11, 1'b0);
    model_pkt(pkt.size());
    send_pkt(pkt.size(), 1);
    compare_all("proto");
    chk("proto_err3", 64'(err[3]), 1);

    // Start byte at payload byte 5 aborts the packet; new one parses with gaps.
    build_pkt(4'd4, 4'd5, 20, 1'b0, 8'h06, 1'b0);
    model_pkt(25);
    send_pkt(25, 2);
    build_pkt(4'd4, 4'd5, 12, 1'b0, 8'h06, 1'b0);
    model_pkt(pkt.size());
    send_pkt(pkt.size(), 2);
    compare_all("abort");

    // Random packets: lengths, options, errors, truncation, gaps, stray bytes.
    for (int it = 0; it < 40; it++) begin
      v  = ($urandom_range(7, 0) == 0) ? 4'd5 : 4'd4;
      ih = ($urandom_range(7, 0) == 0) ? 4'd3 : 4'($urandom_range(8, 5));
      build_pkt(v, ih, $urandom_range(24, 0), $urandom_range(9, 0) == 0,
                ($urandom_range(5, 0) == 0) ? 8'h11 : 8'h06, $urandom_range(5, 0) == 0);
      n_full = pkt.size();
      n_send = ($urandom_range(4, 0) == 0 && n_full > 1) ? $urandom_range(n_full - 1, 1) : n_full;
      model_pkt(n_send);
      send_pkt(n_send, 2);
      if (n_send == n_full) send_junk($urandom_range(2, 0));
      compare_all("rand");
    end

    // Reset during the header, then a clean nominal packet.
    load_nominal();
    send_pkt(7, 0);
    @(negedge clk);
    din_valid = 1'b0; sof = 1'b0; rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    exp_h = {}; exp_p = {};
    load_nominal();
    model_pkt(40);
    send_pkt(40, 1);
    compare_all("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
